// File: rtl/jam_pkg.sv
// Shared JAM types and sizing; also imported by the assignment engine.
package jam_pkg;

  localparam int N_WORKER = 8;
  localparam int COST_W   = 7;
  localparam int SUM_W    = 10;
  localparam int TABLE_N  = N_WORKER * N_WORKER;
  localparam int CNT_W    = 7;

  typedef logic [COST_W-1:0] cost_t;
  typedef logic [2:0]        idx_t;
  typedef logic [SUM_W-1:0]  sum_t;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } tbl_state_e;

  function automatic cost_t cost_min(input cost_t a, input cost_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/jam_rowmin_acc.sv
// Running per-row minimum over a row-major beat stream, summed into a lower bound.
module jam_rowmin_acc
  import jam_pkg::*;
(
  input  logic  CLK,
  input  logic  clear,
  input  logic  beat,
  input  idx_t  col,
  input  cost_t data,
  output sum_t  lower_bound
);

  cost_t rowmin_q;
  cost_t cand;
  sum_t  lb_q;

  // Column 0 starts a new row, so the stale minimum is ignored there.
  assign cand = (col == 3'd0) ? data : cost_min(rowmin_q, data);

  always_ff @(posedge CLK) begin
    if (clear) begin
      rowmin_q <= '0;
      lb_q     <= '0;
    end else if (beat) begin
      rowmin_q <= cand;
      if (col == 3'd7) begin
        lb_q <= lb_q + sum_t'(cand);
      end
    end
  end

  assign lower_bound = lb_q;

endmodule

// File: rtl/jam_cost_table.sv
// 8x8 cost table: streamed load, (W,J) lookup and row-minimum lower bound.
module jam_cost_table
  import jam_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  cost_t            in_data,
  input  logic             Reload,
  input  idx_t             W,
  input  idx_t             J,
  output cost_t            Cost,
  output logic             TableReady,
  output logic [CNT_W-1:0] LoadCount,
  output sum_t             LowerBound,
  output tbl_state_e       dbg_state
);

  // Handshake: a beat transfers on a posedge where in_valid && in_ready,
  // unless Reload is high in that cycle (Reload discards the beat).
  tbl_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             beat;
  cost_t            mem [TABLE_N];

  assign in_ready = (state_q == LOAD) && !RST;
  assign beat     = in_valid && in_ready && !Reload;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (Reload) begin
      state_d = LOAD;
      count_d = '0;
    end else if (beat) begin
      count_d = count_q + 7'd1;
      if (count_q == 7'(TABLE_N - 1)) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (beat) begin
      mem[count_q[5:0]] <= in_data;
    end
  end

  jam_rowmin_acc u_rowmin (
    .CLK        (CLK),
    .clear      (RST || Reload),
    .beat       (beat),
    .col        (count_q[2:0]),
    .data       (in_data),
    .lower_bound(LowerBound)
  );

  generate
    if (REG_OUT) begin : g_reg_out
      always_ff @(posedge CLK) begin
        if (RST) Cost <= '0;
        else     Cost <= mem[{W, J}];
      end
    end else begin : g_comb_out
      assign Cost = mem[{W, J}];
    end
  endgenerate

  assign TableReady = (state_q == READY);
  assign LoadCount  = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table (combinational lookup build).
module tb_jam_cost_table;
  import jam_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  cost_t            in_data;
  logic             Reload;
  idx_t             W;
  idx_t             J;
  cost_t            Cost;
  logic             TableReady;
  logic [CNT_W-1:0] LoadCount;
  sum_t             LowerBound;
  tbl_state_e       dbg_state;

  int total = 0;
  int bad   = 0;

  jam_cost_table #(.REG_OUT(1'b0)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .Reload    (Reload),
    .W         (W),
    .J         (J),
    .Cost      (Cost),
    .TableReady(TableReady),
    .LoadCount (LoadCount),
    .LowerBound(LowerBound),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // kind 0: w+j, kind 1: all 127, kind 2: w*10
  function automatic cost_t entry(input int kind, input int w, input int j);
    case (kind)
      0:       return cost_t'(w + j);
      1:       return cost_t'(127);
      default: return cost_t'(w * 10);
    endcase
  endfunction

  task automatic load_table(input int kind, input int gap, input string tag);
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = entry(kind, i / 8, i % 8);
      if (i == 63) chk({tag, "_ready_before_last"}, TableReady, 0);
      tick();
      in_valid = 1'b0;
      if (i == 9) chk({tag, "_count_10"}, LoadCount, 10);
      for (int g = 0; g < gap; g++) begin
        in_data = cost_t'($urandom_range(0, 127));
        tick();
      end
      if (i == 9 && gap > 0) chk({tag, "_count_hold_gap"}, LoadCount, 10);
    end
  endtask

  task automatic pulse_reload();
    Reload = 1'b1;
    tick();
    Reload = 1'b0;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = '0; Reload = 1'b0; W = '0; J = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_table_ready", TableReady, 0);
    chk("rst_count", LoadCount, 0);
    chk("rst_lb", LowerBound, 0);
    RST = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Test 1: gap-free w+j load
    load_table(0, 0, "t1");
    chk("t1_in_ready", in_ready, 0);
    chk("t1_table_ready", TableReady, 1);
    chk("t1_count", LoadCount, 64);
    chk("t1_lb", LowerBound, 28);

    // Test 3: lookups
    W = 3'd3; J = 3'd5; #1;
    chk("t3_cost_3_5", Cost, 8);
    W = 3'd7; J = 3'd7; #1;
    chk("t3_cost_7_7", Cost, 14);

    // Test 2: reload, then load with in_valid toggling
    pulse_reload();
    chk("t2_reload_ready", TableReady, 0);
    chk("t2_reload_count", LoadCount, 0);
    chk("t2_reload_lb", LowerBound, 0);
    chk("t2_reload_in_ready", in_ready, 1);
    load_table(0, 1, "t2");
    chk("t2_count", LoadCount, 64);
    chk("t2_lb", LowerBound, 28);
    in_valid = 1'b1;
    in_data  = cost_t'(99);
    tick(); tick(); tick();
    in_valid = 1'b0;
    chk("t2_extra_count", LoadCount, 64);
    chk("t2_extra_lb", LowerBound, 28);
    W = 3'd0; J = 3'd0; #1;
    chk("t2_extra_cost_0_0", Cost, 0);
    W = 3'd7; J = 3'd7; #1;
    chk("t2_extra_cost_7_7", Cost, 14);

    // Test 4: saturated entries
    pulse_reload();
    load_table(1, 0, "t4");
    chk("t4_lb", LowerBound, 1016);
    W = 3'd0; J = 3'd0; #1;
    chk("t4_cost_0_0", Cost, 127);

    // Test 5: reload after 20 beats colliding with a valid beat
    pulse_reload();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = cost_t'(5);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_count_20", LoadCount, 20);
    chk("t5_lb_partial", LowerBound, 10);
    in_valid = 1'b1;
    in_data  = cost_t'(0);
    Reload   = 1'b1;
    tick();
    Reload   = 1'b0;
    in_valid = 1'b0;
    chk("t5_drop_count", LoadCount, 0);
    chk("t5_drop_lb", LowerBound, 0);
    load_table(2, 0, "t5");
    chk("t5_lb", LowerBound, 280);
    W = 3'd2; J = 3'd4; #1;
    chk("t5_cost_2_4", Cost, 20);
    W = 3'd0; J = 3'd0; #1;
    chk("t5_cost_0_0", Cost, 0);

    // Test 6: reset while READY
    chk("t6_pre_ready", TableReady, 1);
    RST = 1'b1;
    tick();
    chk("t6_rst_table_ready", TableReady, 0);
    chk("t6_rst_count", LoadCount, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_lb", LowerBound, 0);
    RST = 1'b0;
    tick();
    chk("t6_post_in_ready", in_ready, 1);
    chk("t6_post_state", dbg_state, LOAD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
